alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter ALU_WAIT, default 1, meaning cycles between driving ALU inputs and sampling ALU outputs (legal 1..7).
REQ-002 SHALL have ports:
- clk  in  1  system clock; all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iReq0 / iReq1  in  1  request from requester 0 / 1.
- iOp0 / iOp1  in  4  opcode from requester 0 / 1.
- iA0 / iA1  in  4  first operand from requester 0 / 1.
- iB0 / iB1  in  4  second operand from requester 0 / 1.
- oGnt0 / oGnt1  out  1  one-cycle acceptance pulse.
- oDone0 / oDone1  out  1  one-cycle result-valid pulse.
- oResult  out  4  captured ALU result.
- oFlags  out  5  captured ALU flags.
- oBusy  out  1  high while a transaction is in flight.
- oOpCode  out  4  opcode to the ALU.
- oDato_1  out  4  first operand to the ALU.
- oDato_2  out  4  second operand to the ALU.
- iEntrada  in  4  result from the ALU.
- iFlags  in  5  flags from the ALU.

Function
REQ-003 SHALL implement three states: IDLE, WAIT, DONE.
REQ-004 SHALL sample iReq0/iReq1 only in IDLE; requests in WAIT/DONE SHALL be ignored, not queued.
REQ-005 In IDLE with exactly one request high, SHALL serve that requester regardless of priority.
REQ-006 In IDLE with both high, SHALL serve the requester holding priority; priority pointer SHALL move to the other requester after each grant (round-robin).
REQ-007 On a grant edge SHALL register the winner's op/A/B into oOpCode/oDato_1/oDato_2, record the owner, pulse the owner's oGnt for exactly one cycle, and enter WAIT.
REQ-008 WAIT SHALL last exactly ALU_WAIT cycles (down-counter loaded with ALU_WAIT-1), then enter DONE.
REQ-009 On the WAIT->DONE edge SHALL capture iEntrada into oResult and iFlags into oFlags.
REQ-010 In DONE SHALL pulse the owner's oDone for exactly one cycle, then return to IDLE.
REQ-011 Latency: request high at IDLE edge k -> oGnt high cycle k+1, oDone high cycle k+1+ALU_WAIT; minimum spacing between grants ALU_WAIT+2 cycles.
REQ-012 oOpCode/oDato_1/oDato_2 SHALL hold their last values between transactions; oResult/oFlags SHALL hold until the next capture.
REQ-013 oBusy SHALL be high in WAIT and DONE, low in IDLE.
REQ-014 Opcodes and operands SHALL pass through unmodified; no opcode is rejected.
REQ-015 Requester deasserting iReq after grant SHALL NOT affect an in-flight transaction; a requester still high in IDLE after DONE SHALL be granted again per REQ-005/006.
REQ-016 oGnt0/oGnt1 never high together; oDone0/oDone1 never high together; oGnt and oDone never high in the same cycle.

Reset
REQ-017 iRst high at a clock edge SHALL force IDLE, priority to requester 0, WAIT counter 0, and all outputs to 0.
REQ-018 Reset mid-transaction SHALL abort it: no oDone issued, oResult/oFlags not updated.
REQ-019 iRst SHALL take precedence over every request on the same edge.

Verification
REQ-020 Single request: ALU_WAIT=1, iReq0=1, iOp0=0101, iA0=0011, iB0=0001, ALU model returns 0100 -> oGnt0 at k+1, oOpCode=0101/oDato_1=0011/oDato_2=0001 from k+1, oDone0 at k+2, oResult=0100.
REQ-021 Contention after reset: iReq0=iReq1=1 held -> grants alternate 0,1,0,1; each pair of grants spaced 3 cycles; oDone matches owner each time.
REQ-022 Flag capture: iOp1=0110, iA1=1001, iB1=1001, ALU model iFlags=00001 -> oDone1 pulse, oFlags=00001 held until next transaction.
REQ-023 Latency parameter: ALU_WAIT=4 -> oDone 5 cycles after grant edge; ALU output changed after sampling edge does not alter oResult.
REQ-024 Reset mid-WAIT: iRst high during WAIT -> no oDone, all outputs 0 next cycle, next simultaneous request grants requester 0.
REQ-025 Late request: iReq1 asserted during WAIT of requester 0's transaction and dropped before IDLE -> never granted.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared, externally attached ALU.
// A round-robin arbiter accepts one request at a time, drives the winner's
// opcode and operands to the ALU, waits ALU_WAIT cycles for the ALU to
// settle, captures result and flags, and then signals completion to the
// owner of the transaction. Requests are only looked at while idle.
module alu_arbiter #(
  parameter int ALU_WAIT = 1
) (
  input  logic       clk,
  input  logic       iRst,
  input  logic       iReq0,
  input  logic       iReq1,
  input  logic [3:0] iOp0,
  input  logic [3:0] iOp1,
  input  logic [3:0] iA0,
  input  logic [3:0] iA1,
  input  logic [3:0] iB0,
  input  logic [3:0] iB1,
  output logic       oGnt0,
  output logic       oGnt1,
  output logic       oDone0,
  output logic       oDone1,
  output logic [3:0] oResult,
  output logic [4:0] oFlags,
  output logic       oBusy,
  output logic [3:0] oOpCode,
  output logic [3:0] oDato_1,
  output logic [3:0] oDato_2,
  input  logic [3:0] iEntrada,
  input  logic [4:0] iFlags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter reload value: the WAIT state spans ALU_WAIT cycles, ending when the counter hits zero.
  localparam logic [2:0] WAIT_LOAD = 3'(ALU_WAIT - 1);

  state_t     state_r;
  logic       prio_r;      // requester holding priority on contention
  logic       owner_r;     // requester that owns the in-flight transaction
  logic [2:0] waitCnt_r;

  logic       grantValid_s;
  logic       winner_s;
  logic [3:0] selOp_s;
  logic [3:0] selA_s;
  logic [3:0] selB_s;

  // Pick the requester to serve: a lone request always wins, a tie goes to the priority holder.
  always_comb begin
    grantValid_s = 1'b0;
    winner_s     = 1'b0;
    if (iReq0 && iReq1) begin
      grantValid_s = 1'b1;
      winner_s     = prio_r;
    end else if (iReq0) begin
      grantValid_s = 1'b1;
      winner_s     = 1'b0;
    end else if (iReq1) begin
      grantValid_s = 1'b1;
      winner_s     = 1'b1;
    end else begin
      grantValid_s = 1'b0;
      winner_s     = 1'b0;
    end
  end

  // Route the winner's opcode and operands toward the ALU input registers.
  always_comb begin
    selOp_s = iOp0;
    selA_s  = iA0;
    selB_s  = iB0;
    if (winner_s) begin
      selOp_s = iOp1;
      selA_s  = iA1;
      selB_s  = iB1;
    end else begin
      selOp_s = iOp0;
      selA_s  = iA0;
      selB_s  = iB0;
    end
  end

  // Transaction sequencer: grant, wait for the ALU, capture, signal completion.
  always_ff @(posedge clk) begin
    if (iRst) begin
      state_r   <= IDLE;
      prio_r    <= 1'b0;
      owner_r   <= 1'b0;
      waitCnt_r <= 3'd0;
      oGnt0     <= 1'b0;
      oGnt1     <= 1'b0;
      oDone0    <= 1'b0;
      oDone1    <= 1'b0;
      oResult   <= 4'd0;
      oFlags    <= 5'd0;
      oBusy     <= 1'b0;
      oOpCode   <= 4'd0;
      oDato_1   <= 4'd0;
      oDato_2   <= 4'd0;
    end else begin
      // Grant and done are single-cycle pulses; clear them unless set below.
      oGnt0  <= 1'b0;
      oGnt1  <= 1'b0;
      oDone0 <= 1'b0;
      oDone1 <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grantValid_s) begin
            oOpCode   <= selOp_s;
            oDato_1   <= selA_s;
            oDato_2   <= selB_s;
            owner_r   <= winner_s;
            prio_r    <= ~winner_s;
            oGnt0     <= ~winner_s;
            oGnt1     <= winner_s;
            waitCnt_r <= WAIT_LOAD;
            oBusy     <= 1'b1;
            state_r   <= WAIT;
          end else begin
            oBusy     <= 1'b0;
            state_r   <= IDLE;
          end
        end
        WAIT: begin
          if (waitCnt_r == 3'd0) begin
            oResult <= iEntrada;
            oFlags  <= iFlags;
            oDone0  <= ~owner_r;
            oDone1  <= owner_r;
            state_r <= DONE;
          end else begin
            waitCnt_r <= waitCnt_r - 3'd1;
            state_r   <= WAIT;
          end
        end
        DONE: begin
          oBusy   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          oBusy   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: one instance with ALU_WAIT=1 and one
// with ALU_WAIT=4, each fed by a small adder model standing in for the ALU.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic       owner;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         cyc;
  } gntExp_t;

  typedef struct {
    logic       owner;
    logic [3:0] result;
    logic [4:0] flags;
    int         cyc;
  } doneExp_t;

  gntExp_t  gntQ1[$];
  doneExp_t doneQ1[$];
  gntExp_t  gntQ4[$];
  doneExp_t doneQ4[$];

  // ---------------- DUT with ALU_WAIT = 1 ----------------
  logic       d1Rst, d1Req0, d1Req1;
  logic [3:0] d1Op0, d1Op1, d1A0, d1A1, d1B0, d1B1;
  logic       d1Gnt0, d1Gnt1, d1Done0, d1Done1, d1Busy;
  logic [3:0] d1Result, d1OpCode, d1Dato1, d1Dato2, d1Entrada;
  logic [4:0] d1Flags, d1AluFlags;
  logic       d1Carry;

  assign {d1Carry, d1Entrada} = {1'b0, d1Dato1} + {1'b0, d1Dato2};
  assign d1AluFlags = {4'b0000, d1Carry};

  alu_arbiter #(.ALU_WAIT(1)) dut1 (
    .clk(clk), .iRst(d1Rst), .iReq0(d1Req0), .iReq1(d1Req1),
    .iOp0(d1Op0), .iOp1(d1Op1), .iA0(d1A0), .iA1(d1A1), .iB0(d1B0), .iB1(d1B1),
    .oGnt0(d1Gnt0), .oGnt1(d1Gnt1), .oDone0(d1Done0), .oDone1(d1Done1),
    .oResult(d1Result), .oFlags(d1Flags), .oBusy(d1Busy), .oOpCode(d1OpCode),
    .oDato_1(d1Dato1), .oDato_2(d1Dato2), .iEntrada(d1Entrada), .iFlags(d1AluFlags)
  );

  // ---------------- DUT with ALU_WAIT = 4 ----------------
  logic       d4Rst, d4Req0, d4Req1;
  logic [3:0] d4Op0, d4Op1, d4A0, d4A1, d4B0, d4B1;
  logic       d4Gnt0, d4Gnt1, d4Done0, d4Done1, d4Busy;
  logic [3:0] d4Result, d4OpCode, d4Dato1, d4Dato2, d4Entrada, d4Sum;
  logic [4:0] d4Flags, d4AluFlags;
  logic       d4Carry;
  logic [3:0] aluMask4;

  assign {d4Carry, d4Sum} = {1'b0, d4Dato1} + {1'b0, d4Dato2};
  assign d4Entrada  = d4Sum ^ aluMask4;
  assign d4AluFlags = {4'b0000, d4Carry};

  alu_arbiter #(.ALU_WAIT(4)) dut4 (
    .clk(clk), .iRst(d4Rst), .iReq0(d4Req0), .iReq1(d4Req1),
    .iOp0(d4Op0), .iOp1(d4Op1), .iA0(d4A0), .iA1(d4A1), .iB0(d4B0), .iB1(d4B1),
    .oGnt0(d4Gnt0), .oGnt1(d4Gnt1), .oDone0(d4Done0), .oDone1(d4Done1),
    .oResult(d4Result), .oFlags(d4Flags), .oBusy(d4Busy), .oOpCode(d4OpCode),
    .oDato_1(d4Dato1), .oDato_2(d4Dato2), .iEntrada(d4Entrada), .iFlags(d4AluFlags)
  );

  task automatic checkEq(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      failed = failed + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for the ALU_WAIT=1 instance.
  always @(negedge clk) begin
    gntExp_t  ge;
    doneExp_t de;
    if ((d1Gnt0 | d1Gnt1) && (d1Done0 | d1Done1))
      checkEq("d1 grant/done overlap", 1, 0);
    if (d1Gnt0 | d1Gnt1) begin
      if (gntQ1.size() == 0) checkEq("d1 unexpected grant", int'({d1Gnt1, d1Gnt0}), 0);
      else begin
        ge = gntQ1.pop_front();
        checkEq("d1 grant owner", int'({d1Gnt1, d1Gnt0}), ge.owner ? 2 : 1);
        checkEq("d1 grant cycle", cyc, ge.cyc);
        checkEq("d1 oOpCode", int'(d1OpCode), int'(ge.op));
        checkEq("d1 oDato_1", int'(d1Dato1), int'(ge.a));
        checkEq("d1 oDato_2", int'(d1Dato2), int'(ge.b));
      end
    end
    if (d1Done0 | d1Done1) begin
      if (doneQ1.size() == 0) checkEq("d1 unexpected done", int'({d1Done1, d1Done0}), 0);
      else begin
        de = doneQ1.pop_front();
        checkEq("d1 done owner", int'({d1Done1, d1Done0}), de.owner ? 2 : 1);
        checkEq("d1 done cycle", cyc, de.cyc);
        checkEq("d1 oResult", int'(d1Result), int'(de.result));
        checkEq("d1 oFlags", int'(d1Flags), int'(de.flags));
      end
    end
  end

  // Monitor for the ALU_WAIT=4 instance.
  always @(negedge clk) begin
    gntExp_t  ge;
    doneExp_t de;
    if ((d4Gnt0 | d4Gnt1) && (d4Done0 | d4Done1))
      checkEq("d4 grant/done overlap", 1, 0);
    if (d4Gnt0 | d4Gnt1) begin
      if (gntQ4.size() == 0) checkEq("d4 unexpected grant", int'({d4Gnt1, d4Gnt0}), 0);
      else begin
        ge = gntQ4.pop_front();
        checkEq("d4 grant owner", int'({d4Gnt1, d4Gnt0}), ge.owner ? 2 : 1);
        checkEq("d4 grant cycle", cyc, ge.cyc);
        checkEq("d4 oOpCode", int'(d4OpCode), int'(ge.op));
        checkEq("d4 oDato_1", int'(d4Dato1), int'(ge.a));
        checkEq("d4 oDato_2", int'(d4Dato2), int'(ge.b));
      end
    end
    if (d4Done0 | d4Done1) begin
      if (doneQ4.size() == 0) checkEq("d4 unexpected done", int'({d4Done1, d4Done0}), 0);
      else begin
        de = doneQ4.pop_front();
        checkEq("d4 done owner", int'({d4Done1, d4Done0}), de.owner ? 2 : 1);
        checkEq("d4 done cycle", cyc, de.cyc);
        checkEq("d4 oResult", int'(d4Result), int'(de.result));
        checkEq("d4 oFlags", int'(d4Flags), int'(de.flags));
      end
    end
  end

  task automatic checkReset1(input string name);
    checkEq(name, int'({d1Gnt0, d1Gnt1, d1Done0, d1Done1, d1Result, d1Flags,
                        d1Busy, d1OpCode, d1Dato1, d1Dato2}), 0);
  endtask

  task automatic checkReset4(input string name);
    checkEq(name, int'({d4Gnt0, d4Gnt1, d4Done0, d4Done1, d4Result, d4Flags,
                        d4Busy, d4OpCode, d4Dato1, d4Dato2}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    d1Rst = 1'b1; d1Req0 = 1'b0; d1Req1 = 1'b0;
    d1Op0 = 4'd0; d1Op1 = 4'd0; d1A0 = 4'd0; d1A1 = 4'd0; d1B0 = 4'd0; d1B1 = 4'd0;
    d4Rst = 1'b1; d4Req0 = 1'b0; d4Req1 = 1'b0;
    d4Op0 = 4'd0; d4Op1 = 4'd0; d4A0 = 4'd0; d4A1 = 4'd0; d4B0 = 4'd0; d4B1 = 4'd0;
    aluMask4 = 4'd0;
    tick(2);
    checkReset1("d1 reset outputs");
    checkReset4("d4 reset outputs");
    d1Rst = 1'b0;
    d4Rst = 1'b0;
    tick(2);

    // Single request from requester 0: 3 + 1 = 4.
    c = cyc;
    d1Req0 = 1'b1; d1Op0 = 4'b0101; d1A0 = 4'b0011; d1B0 = 4'b0001;
    gntQ1.push_back('{1'b0, 4'b0101, 4'b0011, 4'b0001, c + 1});
    doneQ1.push_back('{1'b0, 4'b0100, 5'b00000, c + 2});
    tick(1);
    d1Req0 = 1'b0;
    checkEq("d1 busy after grant", int'(d1Busy), 1);
    tick(2);
    checkEq("d1 busy idle", int'(d1Busy), 0);
    checkEq("d1 opcode held", int'(d1OpCode), 5);

    // Flag capture on requester 1: 9 + 9 = 18 -> result 2 with carry.
    c = cyc;
    d1Req1 = 1'b1; d1Op1 = 4'b0110; d1A1 = 4'b1001; d1B1 = 4'b1001;
    gntQ1.push_back('{1'b1, 4'b0110, 4'b1001, 4'b1001, c + 1});
    doneQ1.push_back('{1'b1, 4'b0010, 5'b00001, c + 2});
    tick(1);
    d1Req1 = 1'b0;
    tick(4);
    checkEq("d1 flags held", int'(d1Flags), 1);
    checkEq("d1 result held", int'(d1Result), 2);

    // Late request from requester 1 during requester 0's WAIT must be dropped.
    c = cyc;
    d1Req0 = 1'b1; d1Op0 = 4'b0001; d1A0 = 4'b0010; d1B0 = 4'b0011;
    gntQ1.push_back('{1'b0, 4'b0001, 4'b0010, 4'b0011, c + 1});
    doneQ1.push_back('{1'b0, 4'b0101, 5'b00000, c + 2});
    tick(1);
    d1Req0 = 1'b0;
    d1Req1 = 1'b1; d1Op1 = 4'b1100; d1A1 = 4'b0111; d1B1 = 4'b0111;
    tick(1);
    d1Req1 = 1'b0;
    tick(4);

    // Contention straight after reset: 0,1,0,1 every 3 cycles.
    d1Rst = 1'b1;
    tick(1);
    d1Rst = 1'b0;
    checkReset1("d1 reset before contention");
    c = cyc;
    d1Req0 = 1'b1; d1Op0 = 4'b0001; d1A0 = 4'b0010; d1B0 = 4'b0011;
    d1Req1 = 1'b1; d1Op1 = 4'b1000; d1A1 = 4'b1111; d1B1 = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        gntQ1.push_back('{1'b0, 4'b0001, 4'b0010, 4'b0011, c + 1 + 3 * i});
        doneQ1.push_back('{1'b0, 4'b0101, 5'b00000, c + 2 + 3 * i});
      end else begin
        gntQ1.push_back('{1'b1, 4'b1000, 4'b1111, 4'b0001, c + 1 + 3 * i});
        doneQ1.push_back('{1'b1, 4'b0000, 5'b00001, c + 2 + 3 * i});
      end
    end
    tick(10);
    d1Req0 = 1'b0;
    d1Req1 = 1'b0;
    tick(4);

    // ALU_WAIT=4: 5 + 6 = 11, done five cycles after the grant edge.
    c = cyc;
    d4Req0 = 1'b1; d4Op0 = 4'b0011; d4A0 = 4'b0101; d4B0 = 4'b0110;
    gntQ4.push_back('{1'b0, 4'b0011, 4'b0101, 4'b0110, c + 1});
    doneQ4.push_back('{1'b0, 4'b1011, 5'b00000, c + 5});
    tick(1);
    d4Req0 = 1'b0;
    tick(4);
    aluMask4 = 4'b1111;
    tick(2);
    checkEq("d4 result unaffected by late ALU change", int'(d4Result), 11);
    aluMask4 = 4'b0000;

    // Reset during WAIT aborts the transaction (priority was left at 1).
    c = cyc;
    d4Req0 = 1'b1; d4Op0 = 4'b0100; d4A0 = 4'b0001; d4B0 = 4'b0001;
    gntQ4.push_back('{1'b0, 4'b0100, 4'b0001, 4'b0001, c + 1});
    tick(1);
    d4Req0 = 1'b0;
    tick(1);
    checkEq("d4 busy in WAIT", int'(d4Busy), 1);
    d4Rst = 1'b1;
    tick(1);
    d4Rst = 1'b0;
    checkReset4("d4 reset mid-WAIT outputs");
    tick(6);

    // Simultaneous request after reset goes to requester 0.
    c = cyc;
    d4Req0 = 1'b1; d4Op0 = 4'b0111; d4A0 = 4'b0010; d4B0 = 4'b0010;
    d4Req1 = 1'b1; d4Op1 = 4'b1001; d4A1 = 4'b0001; d4B1 = 4'b0001;
    gntQ4.push_back('{1'b0, 4'b0111, 4'b0010, 4'b0010, c + 1});
    doneQ4.push_back('{1'b0, 4'b0100, 5'b00000, c + 5});
    tick(1);
    d4Req0 = 1'b0;
    d4Req1 = 1'b0;
    tick(7);

    checkEq("d1 pending grants", gntQ1.size(), 0);
    checkEq("d1 pending dones", doneQ1.size(), 0);
    checkEq("d4 pending grants", gntQ4.size(), 0);
    checkEq("d4 pending dones", doneQ4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
